// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue side of the 64-bit ALU operand/control/result interface.
// Accepts (aluop, funct, A, B) over valid/ready, decodes it to the 4-bit ALU
// control code, drives registered operands to a combinational ALU, captures
// its result/zero flag and returns them over a second valid/ready handshake.
// Optional feature macro: ALU_NOR_EN (ALUOP=10, funct 0100 decodes to NOR).
module alu_issue_ctrl #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_aluop,
  input  logic [3:0]        req_funct,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zeroflag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_PASS = 4'b0111;
`ifdef ALU_NOR_EN
  localparam logic [3:0] CTL_NOR  = 4'b1100;
`endif

  state_t     state, state_nxt;
  logic       dec_legal;
  logic [3:0] dec_ctrl;
  logic       accept;
  logic       rsp_fire;

  // Decode the request into an ALU control code and a legality flag.
  always_comb begin
    dec_legal = 1'b1;
    dec_ctrl  = CTL_ADD;
    case (req_aluop)
      2'b00: dec_ctrl = CTL_ADD;
      2'b01: dec_ctrl = CTL_SUB;
      2'b11: dec_ctrl = CTL_PASS;
      default: begin
        case (req_funct)
          4'b0000: dec_ctrl = CTL_ADD;
          4'b1000: dec_ctrl = CTL_SUB;
          4'b0111: dec_ctrl = CTL_AND;
          4'b0110: dec_ctrl = CTL_OR;
`ifdef ALU_NOR_EN
          4'b0100: dec_ctrl = CTL_NOR;
`endif
          default: begin
            dec_legal = 1'b0;
            dec_ctrl  = CTL_ADD;
          end
        endcase
      end
    endcase
  end

  // Next-state and handshake outputs; only IDLE takes requests.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = dec_legal ? EXEC : RESP;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Operand/control registers feeding the ALU; untouched by illegal requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
    end else if (accept && dec_legal) begin
      alu_a       <= req_a;
      alu_b       <= req_b;
      alu_control <= dec_ctrl;
    end
  end

  // Response capture: ALU outputs after the exec cycle, or a zeroed illegal reply.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else if (accept && !dec_legal) begin
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b1;
    end else if (state == EXEC) begin
      rsp_result  <= alu_result;
      rsp_zero    <= alu_zeroflag;
      rsp_illegal <= 1'b0;
    end
  end

  // Completed-response counter, sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    op_count <= '0;
    else if (rsp_fire && !(&op_count)) op_count <= op_count + 1'b1;
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vector table, hand-written reset/saturation
// sequences and randomized operations against a behavioural reference model.
module tb_alu_issue_ctrl;
  localparam int DW = 64;
  localparam int CW = 2;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic          clk;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_aluop;
  logic [3:0]    req_funct;
  logic [DW-1:0] req_a, req_b;
  logic [DW-1:0] alu_a, alu_b;
  logic [3:0]    alu_control;
  logic [DW-1:0] alu_result;
  logic          alu_zeroflag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero;
  logic          rsp_illegal;
  logic [CW-1:0] op_count;

  alu_issue_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zeroflag(alu_zeroflag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU standing in for the real one.
  always_comb begin
    case (alu_control)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0111: alu_result = alu_b;
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
    alu_zeroflag = (alu_result == '0);
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: last legal operands/control and completed-op count.
  logic [DW-1:0] m_a, m_b;
  logic [3:0]    m_ctrl;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // What the datapath should see for a request, straight from the op semantics.
  task automatic ref_op(input logic [1:0] op, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b,
                        output logic ill, output logic [3:0] ctrl,
                        output logic [63:0] res);
    ill = 1'b0; ctrl = 4'b0010; res = 64'd0;
    if (op == 2'b00)      begin ctrl = 4'b0010; res = a + b; end
    else if (op == 2'b01) begin ctrl = 4'b0110; res = a - b; end
    else if (op == 2'b11) begin ctrl = 4'b0111; res = b; end
    else if (fn == 4'b0000) begin ctrl = 4'b0010; res = a + b; end
    else if (fn == 4'b1000) begin ctrl = 4'b0110; res = a - b; end
    else if (fn == 4'b0111) begin ctrl = 4'b0000; res = a & b; end
    else if (fn == 4'b0110) begin ctrl = 4'b0001; res = a | b; end
`ifdef ALU_NOR_EN
    else if (fn == 4'b0100) begin ctrl = 4'b1100; res = ~(a | b); end
`endif
    else ill = 1'b1;
  endtask

  // One full transaction starting in IDLE at posedge+1; returns in IDLE at posedge+1.
  task automatic run_op(input logic [1:0] op, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eres, input logic ezero,
                        input logic eill, input logic [3:0] ectrl,
                        input int hold);
    req_valid = 1'b1; req_aluop = op; req_funct = fn; req_a = a; req_b = b;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    // Garbage on the request side while busy must be ignored.
    req_valid = 1'($urandom); req_aluop = 2'($urandom); req_funct = 4'($urandom);
    req_a = {$urandom, $urandom}; req_b = {$urandom, $urandom};
    if (!eill) begin
      chk("exec_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("exec_req_ready", 64'(req_ready), 64'd0);
      chk("alu_a", alu_a, a);
      chk("alu_b", alu_b, b);
      chk("alu_control", 64'(alu_control), 64'(ectrl));
      m_a = a; m_b = b; m_ctrl = ectrl;
      @(posedge clk); #1;
    end else begin
      chk("ill_alu_a_hold", alu_a, m_a);
      chk("ill_alu_b_hold", alu_b, m_b);
      chk("ill_alu_ctrl_hold", 64'(alu_control), 64'(m_ctrl));
    end
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_result", rsp_result, eres);
    chk("rsp_zero", 64'(rsp_zero), 64'(ezero));
    chk("rsp_illegal", 64'(rsp_illegal), 64'(eill));
    chk("resp_req_ready", 64'(req_ready), 64'd0);
    chk("resp_op_count", 64'(op_count), 64'(m_cnt));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_result", rsp_result, eres);
      chk("hold_rsp_zero", 64'(rsp_zero), 64'(ezero));
      chk("hold_rsp_illegal", 64'(rsp_illegal), 64'(eill));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_op_count", 64'(op_count), 64'(m_cnt));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    if (m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
    chk("done_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("done_req_ready", 64'(req_ready), 64'd1);
    chk("done_op_count", 64'(op_count), 64'(m_cnt));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_alu_control", 64'(alu_control), 64'd0);
    chk("rst_rsp_result", rsp_result, 64'd0);
    chk("rst_rsp_zero", 64'(rsp_zero), 64'd0);
    chk("rst_rsp_illegal", 64'(rsp_illegal), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  fn;
    logic [63:0] a, b, res;
    logic        zero, ill;
    logic [3:0]  ctrl;
  } vec_t;

  vec_t vt[12];
  logic [CW-1:0] sat_exp[5];
  logic [3:0]    legal_fn[5];

  initial begin
    vt[0]  = '{2'b10, 4'b0000, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0, 4'b0010};
    vt[1]  = '{2'b01, 4'b0000, 64'h1234, 64'h1234, 64'd0, 1'b1, 1'b0, 4'b0110};
    vt[2]  = '{2'b10, 4'b1000, 64'd10, 64'd3, 64'd7, 1'b0, 1'b0, 4'b0110};
    vt[3]  = '{2'b10, 4'b0111, 64'hF0, 64'h3C, 64'h30, 1'b0, 1'b0, 4'b0000};
    vt[4]  = '{2'b10, 4'b0001, 64'd9, 64'd9, 64'd0, 1'b0, 1'b1, 4'b0000};
    vt[5]  = '{2'b10, 4'b0110, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0, 4'b0001};
    vt[6]  = '{2'b00, 4'b1111, 64'd1, 64'd2, 64'd3, 1'b0, 1'b0, 4'b0010};
    vt[7]  = '{2'b11, 4'b0101, 64'hAAAA, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 4'b0111};
`ifdef ALU_NOR_EN
    vt[8]  = '{2'b10, 4'b0100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4'b1100};
`else
    vt[8]  = '{2'b10, 4'b0100, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 4'b0000};
`endif
    vt[9]  = '{2'b01, 4'b0000, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4'b0110};
    vt[10] = '{2'b00, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 4'b0010};
    vt[11] = '{2'b10, 4'b1111, 64'd4, 64'd4, 64'd0, 1'b0, 1'b1, 4'b0000};
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    legal_fn[0] = 4'b0000; legal_fn[1] = 4'b1000; legal_fn[2] = 4'b0111;
    legal_fn[3] = 4'b0110; legal_fn[4] = 4'b0100;

    reset_n = 1'b1; req_valid = 1'b0; req_aluop = '0; req_funct = '0;
    req_a = '0; req_b = '0; rsp_ready = 1'b0;
    m_a = '0; m_b = '0; m_ctrl = '0; m_cnt = '0;
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table; illegal rows leave the ALU registers alone.
    for (int i = 0; i < 12; i++)
      run_op(vt[i].op, vt[i].fn, vt[i].a, vt[i].b, vt[i].res, vt[i].zero,
             vt[i].ill, vt[i].ill ? m_ctrl : vt[i].ctrl, (i == 1) ? 3 : (i % 2));

    // Reset in the middle of EXEC aborts the operation outright.
    req_valid = 1'b1; req_aluop = 2'b10; req_funct = 4'b0000; req_a = 64'd9; req_b = 64'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_exec", 64'(rsp_valid), 64'd0);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs();
    m_a = '0; m_b = '0; m_ctrl = '0; m_cnt = '0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back legal ops after reset: counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      run_op(2'b00, 4'b0000, 64'(i), 64'd100, 64'(i + 100), 1'b0, 1'b0, 4'b0010, 0);
      chk("sat_count", 64'(op_count), 64'(sat_exp[i]));
    end

    // Randomized operations checked against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [1:0]  op;
      logic [3:0]  fn;
      logic [63:0] a, b, res;
      logic        ill;
      logic [3:0]  ctrl;
      op = 2'($urandom);
      fn = ($urandom_range(0, 3) != 0) ? legal_fn[$urandom_range(0, 4)] : 4'($urandom);
      a  = {$urandom, $urandom};
      b  = ($urandom_range(0, 4) == 0) ? a : {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) b = 64'd0;
      ref_op(op, fn, a, b, ill, ctrl, res);
      run_op(op, fn, a, b, ill ? 64'd0 : res, ill ? 1'b0 : (res == 64'd0), ill,
             ill ? m_ctrl : ctrl, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
